alu_exec: RTL and testbench

//  Execution-stage ALU that consumes the 4-bit alu_ct code from the ALU control decoder and produces
//  the result. Single-cycle ops have 1-cycle registered latency. MULTU (alu_ct=4'b1001) runs on a
//  32-step serial shift-add unit. Valid/ready handshake on both sides lets the pipeline stall it.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_exec_if.sv | 26 ++
 rtl/alu_mul_serial.sv | 59 +++++
 rtl/alu_exec.sv | 100 ++++++++++
 tb/tb_alu_exec.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, default widths and execution-stage state encoding.
// Also used by the ALU control decoder.
package alu_pkg;

  localparam int unsigned ALU_WIDTH     = 32;
  localparam int unsigned ALU_MUL_STEPS = 32;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;

  typedef enum logic {IDLE, MUL} alu_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Valid/ready operand and result bus between the pipeline and the execution-stage ALU.
interface alu_exec_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, alu_ct, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, busy
  );

  modport slave (
    input  in_valid, alu_ct, src_a, src_b, out_ready,
    output in_ready, out_valid, result, result_hi, zero, busy
  );
endinterface

// File: rtl/alu_mul_serial.sv
// Serial shift-add unsigned multiplier: one partial-product step per cycle, STEPS cycles per op.
// done_c and the {hi_c,lo_c} product are valid combinationally during the final step.
module alu_mul_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned STEPS = ALU_MUL_STEPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic             running;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   sum_c;

  // Conditional add keeps its carry, which shifts down into the accumulator msb.
  always_comb begin
    sum_c  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    hi_c   = sum_c[WIDTH:1];
    lo_c   = {sum_c[0], mplier[WIDTH-1:1]};
    done_c = running && (count == CNT_W'(STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      mcand   <= a;
      acc     <= '0;
      mplier  <= b;
    end else if (running) begin
      acc     <= hi_c;
      mplier  <= lo_c;
      count   <= count + CNT_W'(1);
      if (done_c) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle logic/arith ops with a registered result, plus a serial MULTU.
// Valid/ready on both sides; the result is held until the consumer takes it.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = ALU_WIDTH,
  parameter int unsigned MUL_STEPS = ALU_MUL_STEPS
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  alu_state_t       state;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             busy;

  logic             in_ready_c;
  logic             accept_c;
  logic             mul_start_c;
  logic [WIDTH-1:0] op_res_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_hi_c;
  logic [WIDTH-1:0] mul_lo_c;

  assign in_ready_c  = (state == IDLE) && (!out_valid || bus.out_ready);
  assign accept_c    = bus.in_valid && in_ready_c;
  assign mul_start_c = accept_c && (bus.alu_ct == ALU_MULTU);

  // Single-cycle ops; unknown codes (and MULTU, handled serially) give zero.
  always_comb begin
    op_res_c = '0;
    case (bus.alu_ct)
      ALU_AND:  op_res_c = bus.src_a & bus.src_b;
      ALU_OR:   op_res_c = bus.src_a | bus.src_b;
      ALU_ADD:  op_res_c = bus.src_a + bus.src_b;
      ALU_XOR:  op_res_c = bus.src_a ^ bus.src_b;
      ALU_NOR:  op_res_c = ~(bus.src_a | bus.src_b);
      ALU_SUB:  op_res_c = bus.src_a - bus.src_b;
      ALU_SLTU: op_res_c = WIDTH'(bus.src_a < bus.src_b);
      default:  op_res_c = '0;
    endcase
  end

  alu_mul_serial #(
    .WIDTH (WIDTH),
    .STEPS (MUL_STEPS)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start_c),
    .a      (bus.src_a),
    .b      (bus.src_b),
    .done_c (mul_done_c),
    .hi_c   (mul_hi_c),
    .lo_c   (mul_lo_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      busy      <= 1'b0;
    end else if (state == IDLE) begin
      if (mul_start_c) begin
        state     <= MUL;
        busy      <= 1'b1;
        out_valid <= 1'b0;
      end else if (accept_c) begin
        out_valid <= 1'b1;
        result    <= op_res_c;
        result_hi <= '0;
        zero      <= (op_res_c == '0);
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (mul_done_c) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b1;
      result    <= mul_lo_c;
      result_hi <= mul_hi_c;
      zero      <= (mul_lo_c == '0);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.result_hi = result_hi;
  assign bus.zero      = zero;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, hand sequences for multiply/stall/reset,
// and a random phase checked against a transaction-level model of the ALU.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int unsigned W  = ALU_WIDTH;
  localparam int unsigned W2 = 2 * ALU_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec #(.WIDTH(W), .MUL_STEPS(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending result, output-valid flag and cycles left on a multiply.
  bit            m_ov;
  logic [W2-1:0] m_res;
  logic [W2-1:0] m_mul_res;
  int            m_mul_left;

  typedef struct {
    logic [3:0]   ct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
  } vec_t;

  function automatic logic [W2-1:0] ref_op(logic [3:0] ct, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] t;
    t = '0;
    case (ct)
      ALU_AND:   t = a & b;
      ALU_OR:    t = a | b;
      ALU_ADD:   t = a + b;
      ALU_XOR:   t = a ^ b;
      ALU_NOR:   t = ~(a | b);
      ALU_SUB:   t = a - b;
      ALU_SLTU:  t = (a < b) ? W'(1) : W'(0);
      ALU_MULTU: return W2'(a) * W2'(b);
      default:   t = '0;
    endcase
    return W2'(t);
  endfunction

  task automatic chk(string name, logic [W2-1:0] act, logic [W2-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit v, logic [3:0] ct, logic [W-1:0] a, logic [W-1:0] b, bit ordy);
    bus.in_valid  = v;
    bus.alu_ct    = ct;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.out_ready = ordy;
  endtask

  task automatic model_reset();
    m_ov = 0; m_res = '0; m_mul_res = '0; m_mul_left = 0;
  endtask

  // One clock: check in_ready against the model, clock, advance model, check outputs.
  task automatic step(string tag);
    bit            exp_rdy;
    bit            acc;
    bit            ordy;
    logic [3:0]    ct;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    #1;
    exp_rdy = (m_mul_left == 0) && (!m_ov || bus.out_ready);
    chk({tag, " in_ready"}, W2'(bus.in_ready), W2'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    ordy = bus.out_ready; ct = bus.alu_ct; a = bus.src_a; b = bus.src_b;
    @(posedge clk);
    if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_ov  = 1;
        m_res = m_mul_res;
      end
    end else if (acc) begin
      if (ct == ALU_MULTU) begin
        m_mul_left = W;
        m_ov       = 0;
        m_mul_res  = ref_op(ct, a, b);
      end else begin
        m_ov  = 1;
        m_res = ref_op(ct, a, b);
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    #1;
    chk({tag, " out_valid"}, W2'(bus.out_valid), W2'(m_ov));
    chk({tag, " busy"}, W2'(bus.busy), W2'(m_mul_left > 0));
    if (m_ov) begin
      chk({tag, " result"}, W2'(bus.result), W2'(m_res[W-1:0]));
      chk({tag, " result_hi"}, W2'(bus.result_hi), W2'(m_res[W2-1:W]));
      chk({tag, " zero"}, W2'(bus.zero), W2'(m_res[W-1:0] == '0));
    end
  endtask

  vec_t vecs[12];
  logic [3:0] codes[8];

  initial begin
    vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0, 1'b1};
    vecs[1]  = '{ALU_SUB,  32'h5,         32'h7,         32'hFFFF_FFFE, 32'h0, 1'b0};
    vecs[2]  = '{ALU_SLTU, 32'h5,         32'h7,         32'h1,         32'h0, 1'b0};
    vecs[3]  = '{ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 32'h0, 1'b0};
    vecs[4]  = '{ALU_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 32'h0, 1'b0};
    vecs[5]  = '{ALU_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 32'h0, 1'b0};
    vecs[6]  = '{ALU_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 32'h0, 1'b0};
    vecs[7]  = '{ALU_SLTU, 32'h7,         32'h5,         32'h0,         32'h0, 1'b1};
    vecs[8]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0, 1'b0};
    vecs[9]  = '{ALU_SUB,  32'h9,         32'h9,         32'h0,         32'h0, 1'b1};
    vecs[10] = '{4'b0101,  32'h1234_5678, 32'h1,         32'h0,         32'h0, 1'b1};
    vecs[11] = '{4'b1111,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0, 1'b1};
    codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SUB, ALU_SLTU, ALU_MULTU};

    // Reset state
    rst = 1'b0;
    drive(0, ALU_AND, '0, '0, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", W2'(bus.out_valid), '0);
    chk("rst result", W2'(bus.result), '0);
    chk("rst result_hi", W2'(bus.result_hi), '0);
    chk("rst zero", W2'(bus.zero), '0);
    chk("rst busy", W2'(bus.busy), '0);
    chk("rst in_ready", W2'(bus.in_ready), W2'(1));
    rst = 1'b1;

    // Directed table, back-to-back at one op per cycle
    foreach (vecs[i]) begin
      drive(1, vecs[i].ct, vecs[i].a, vecs[i].b, 1);
      #1;
      chk("tbl in_ready", W2'(bus.in_ready), W2'(1));
      step("tbl");
      chk("tbl out_valid", W2'(bus.out_valid), W2'(1));
      chk("tbl result", W2'(bus.result), W2'(vecs[i].lo));
      chk("tbl result_hi", W2'(bus.result_hi), W2'(vecs[i].hi));
      chk("tbl zero", W2'(bus.zero), W2'(vecs[i].z));
    end
    drive(0, ALU_AND, '0, '0, 1);
    step("drain");

    // MULTU 0xFFFFFFFF * 2, inputs toggling while in flight
    drive(1, ALU_MULTU, 32'hFFFF_FFFF, 32'h2, 1);
    step("mul acc");
    for (int i = 1; i <= 32; i++) begin
      drive(1, ALU_ADD, $urandom, $urandom, 1);
      #1;
      chk("mul in_ready", W2'(bus.in_ready), '0);
      step("mul");
      if (i < 32) begin
        chk("mul busy", W2'(bus.busy), W2'(1));
        chk("mul early valid", W2'(bus.out_valid), '0);
      end else begin
        chk("mul valid", W2'(bus.out_valid), W2'(1));
        chk("mul lo", W2'(bus.result), W2'(32'hFFFF_FFFE));
        chk("mul hi", W2'(bus.result_hi), W2'(1));
        chk("mul done busy", W2'(bus.busy), '0);
      end
    end
    drive(0, ALU_AND, '0, '0, 1);
    step("drain");

    // Output hold under back-pressure
    drive(1, ALU_OR, 32'h1, 32'h2, 0);
    step("hold acc");
    for (int i = 0; i < 5; i++) begin
      drive(1, ALU_ADD, $urandom, $urandom, 0);
      #1;
      chk("hold in_ready", W2'(bus.in_ready), '0);
      step("hold");
      chk("hold result", W2'(bus.result), W2'(3));
      chk("hold valid", W2'(bus.out_valid), W2'(1));
    end
    drive(0, ALU_AND, '0, '0, 1);
    step("hold drain");
    chk("hold drained", W2'(bus.out_valid), '0);

    // Reset during a multiply
    drive(1, ALU_MULTU, $urandom, $urandom, 1);
    step("rmul acc");
    drive(0, ALU_AND, '0, '0, 1);
    for (int i = 0; i < 9; i++) step("rmul");
    rst = 1'b0;
    #1;
    model_reset();
    chk("abort out_valid", W2'(bus.out_valid), '0);
    chk("abort busy", W2'(bus.busy), '0);
    chk("abort in_ready", W2'(bus.in_ready), W2'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, ALU_ADD, 32'h2, 32'h3, 1);
    step("post add");
    chk("post add result", W2'(bus.result), W2'(5));
    drive(1, 4'b1111, 32'h2, 32'h3, 1);
    step("post bad");
    chk("post bad result", W2'(bus.result), '0);
    chk("post bad zero", W2'(bus.zero), W2'(1));
    chk("post bad hi", W2'(bus.result_hi), '0);

    // Random traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      logic [3:0]   ct;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int unsigned  r;
      r = $urandom_range(0, 15);
      if (r < 13) ct = codes[$urandom_range(0, 6)];
      else if (r == 13) ct = ALU_MULTU;
      else ct = 4'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      drive($urandom_range(0, 3) != 0, ct, a, b, $urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
